// File: rtl/boot_loader_if.sv
// boot_loader_if: byte-stream handshake, instruction-memory write port and
// boot status grouped into one bundle. The slave modport is the loader side;
// the master modport is the upstream byte source / downstream observer side.
interface boot_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_run;
    logic              boot_error;
    logic [15:0]       words_loaded;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output core_run,
        output boot_error,
        output words_loaded
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  core_run,
        input  boot_error,
        input  words_loaded
    );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: receives a framed program image (0xA5, LEN_LO, LEN_HI, 4*N data
// bytes LSB first) and writes little-endian 32-bit words into the core's
// instruction memory, then releases the core via core_run.
// Optional build macro BOOT_CHECKSUM_EN appends a one-byte mod-256 sum of the
// data bytes to the frame; a mismatch ends in the error state.
module boot_loader #(
    parameter int IMEM_WORDS = 256,
    parameter int ADDR_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.slave  bus
);

    localparam logic [7:0]  MAGIC     = 8'hA5;
    localparam logic [15:0] MAX_WORDS = 16'(IMEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
`ifdef BOOT_CHECKSUM_EN
        S_CSUM   = 3'd4,
`endif
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

`ifdef BOOT_CHECKSUM_EN
    // Running checksum step: 8-bit sum that wraps modulo 256.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction
`endif

    state_t            r_state;
    logic              r_in_ready;
    logic              r_imem_we;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic              r_core_run;
    logic              r_boot_error;
    logic [15:0]       r_words_loaded;
    logic [15:0]       r_len;
    logic [1:0]        r_byte_idx;
    logic [23:0]       r_word;      // bytes 0..2 of the word in progress, byte 0 lowest
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic              w_accept;
    logic [15:0]       w_len_full;
    logic [15:0]       w_words_next;

    assign w_accept     = bus.in_valid & r_in_ready;
    assign w_len_full   = {bus.in_data, r_len[7:0]};
    assign w_words_next = r_words_loaded + 16'd1;

    assign bus.in_ready     = r_in_ready;
    assign bus.imem_we      = r_imem_we;
    assign bus.imem_addr    = r_imem_addr;
    assign bus.imem_wdata   = r_imem_wdata;
    assign bus.core_run     = r_core_run;
    assign bus.boot_error   = r_boot_error;
    assign bus.words_loaded = r_words_loaded;

    // Frame parser FSM with all outputs registered; in_ready drops in the same
    // edge that enters DONE/ERROR, core_run rises one cycle after DONE entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_in_ready     <= 1'b1;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= '0;
            r_imem_wdata   <= 32'h0000_0000;
            r_core_run     <= 1'b0;
            r_boot_error   <= 1'b0;
            r_words_loaded <= 16'h0000;
            r_len          <= 16'h0000;
            r_byte_idx     <= 2'd0;
            r_word         <= 24'h00_0000;
`ifdef BOOT_CHECKSUM_EN
            r_csum         <= 8'h00;
`endif
        end else begin
            // The write strobe is a single-cycle pulse unless re-armed below.
            r_imem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Non-magic bytes are silently dropped to resynchronise.
                    if (w_accept && (bus.in_data == MAGIC)) begin
                        r_state <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len[7:0] <= bus.in_data;
                        r_state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_accept) begin
                        r_len[15:8] <= bus.in_data;
                        if (w_len_full > MAX_WORDS) begin
                            r_state      <= S_ERROR;
                            r_in_ready   <= 1'b0;
                            r_boot_error <= 1'b1;
                        end else if (w_len_full == 16'h0000) begin
`ifdef BOOT_CHECKSUM_EN
                            r_state    <= S_CSUM;
`else
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
`endif
                        end else begin
                            r_state    <= S_DATA;
                            r_byte_idx <= 2'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
`ifdef BOOT_CHECKSUM_EN
                        r_csum <= csum_add(r_csum, bus.in_data);
`endif
                        r_word     <= {bus.in_data, r_word[23:8]};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            // Byte 3 completes the word; the write lands next cycle.
                            r_imem_we      <= 1'b1;
                            r_imem_addr    <= r_words_loaded[ADDR_W-1:0];
                            r_imem_wdata   <= {bus.in_data, r_word};
                            r_words_loaded <= w_words_next;
                            if (w_words_next == r_len) begin
`ifdef BOOT_CHECKSUM_EN
                                r_state    <= S_CSUM;
`else
                                r_state    <= S_DONE;
                                r_in_ready <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                S_CSUM: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (bus.in_data == r_csum) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state      <= S_ERROR;
                            r_boot_error <= 1'b1;
                        end
                    end
                end
`endif
                S_DONE: begin
                    r_in_ready <= 1'b0;
                    r_core_run <= 1'b1;
                end
                S_ERROR: begin
                    r_in_ready   <= 1'b0;
                    r_boot_error <= 1'b1;
                end
                default: begin
                    r_state      <= S_ERROR;
                    r_in_ready   <= 1'b0;
                    r_boot_error <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: table-driven cycle vectors for the basic two-word frame,
// plus directed sequences for resync, length limits, reset abort and gaps.
module tb_boot_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;

    boot_loader_if #(.ADDR_W(8)) bus ();

    boot_loader #(.IMEM_WORDS(256), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [15:0] words;
        logic        ready;
        logic        run;
        logic        err;
    } vec_t;

    vec_t        tab [16];
    int          n_tab = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [39:0] wr_q [$];
    logic [7:0]  f1 [11];
    logic [7:0]  csum1;

    // Write monitor: records every imem write as {addr, data}, mid-cycle.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) wr_q.push_back({bus.imem_addr, bus.imem_wdata});
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic v, input logic [7:0] d, input logic we,
                           input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [15:0] words, input logic ready,
                           input logic run, input logic err);
        tab[n_tab] = '{v, d, we, addr, wdata, words, ready, run, err};
        n_tab++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wr_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] d);
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 0) break;
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        send_byte(d);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame1(input bit gaps);
        for (int k = 0; k < 11; k++) begin
            if (gaps) send_gap(f1[k]);
            else      send_byte(f1[k]);
        end
`ifdef BOOT_CHECKSUM_EN
        if (gaps) send_gap(csum1);
        else      send_byte(csum1);
`endif
    endtask

    task automatic send_frame2(input logic [7:0] cs);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
`ifdef BOOT_CHECKSUM_EN
        send_byte(cs);
`endif
    endtask

    task automatic chk_status(input string nm, input logic [15:0] words,
                              input logic ready, input logic run, input logic err);
        chk({nm, "_words"}, 64'(bus.words_loaded), 64'(words));
        chk({nm, "_ready"}, 64'(bus.in_ready), 64'(ready));
        chk({nm, "_run"},   64'(bus.core_run), 64'(run));
        chk({nm, "_err"},   64'(bus.boot_error), 64'(err));
    endtask

    task automatic chk_wr(input string nm, input int n, input logic [39:0] e0, input logic [39:0] e1);
        chk({nm, "_wrcnt"}, 64'(wr_q.size()), 64'(n));
        if (n >= 1 && wr_q.size() >= 1) chk({nm, "_wr0"}, 64'(wr_q[0]), 64'(e0));
        if (n >= 2 && wr_q.size() >= 2) chk({nm, "_wr1"}, 64'(wr_q[1]), 64'(e1));
    endtask

    initial begin
        logic [7:0] cs_last;
        f1 = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        csum1 = 8'h00;
        for (int k = 3; k < 11; k++) csum1 = csum1 + f1[k];

        // Expected per-cycle outputs after each edge for the two-word frame.
        for (int k = 0; k < 6; k++)
            add_vec(1'b1, f1[k], 1'b0, 8'h00, 32'h0, 16'd0, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, f1[6], 1'b1, 8'h00, 32'h0010_0013, 16'd1, 1'b1, 1'b0, 1'b0);
        for (int k = 7; k < 10; k++)
            add_vec(1'b1, f1[k], 1'b0, 8'h00, 32'h0, 16'd1, 1'b1, 1'b0, 1'b0);
`ifdef BOOT_CHECKSUM_EN
        add_vec(1'b1, f1[10], 1'b1, 8'h01, 32'h0010_0093, 16'd2, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, csum1,  1'b0, 8'h00, 32'h0, 16'd2, 1'b0, 1'b0, 1'b0);
`else
        add_vec(1'b1, f1[10], 1'b1, 8'h01, 32'h0010_0093, 16'd2, 1'b0, 1'b0, 1'b0);
`endif
        add_vec(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 16'd2, 1'b0, 1'b1, 1'b0);
        add_vec(1'b0, 8'h00, 1'b0, 8'h00, 32'h0, 16'd2, 1'b0, 1'b1, 1'b0);

        // Reset state.
        do_reset();
        chk("rst_we", 64'(bus.imem_we), 64'd0);
        chk("rst_addr", 64'(bus.imem_addr), 64'd0);
        chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
        chk_status("rst", 16'd0, 1'b1, 1'b0, 1'b0);

        // Test 1: back-to-back frame, checked every cycle.
        for (int i = 0; i < n_tab; i++) begin
            bus.in_valid = tab[i].v;
            bus.in_data  = tab[i].d;
            @(posedge clk);
            #1;
            n_vec++;
            if (bus.imem_we !== tab[i].we || bus.words_loaded !== tab[i].words ||
                bus.in_ready !== tab[i].ready || bus.core_run !== tab[i].run ||
                bus.boot_error !== tab[i].err ||
                (tab[i].we && (bus.imem_addr !== tab[i].addr || bus.imem_wdata !== tab[i].wdata))) begin
                n_bad++;
                $display("FAIL t1_vec%0d: got we=%b addr=%0h wd=%0h words=%0d rdy=%b run=%b err=%b expected we=%b addr=%0h wd=%0h words=%0d rdy=%b run=%b err=%b",
                         i, bus.imem_we, bus.imem_addr, bus.imem_wdata, bus.words_loaded,
                         bus.in_ready, bus.core_run, bus.boot_error,
                         tab[i].we, tab[i].addr, tab[i].wdata, tab[i].words,
                         tab[i].ready, tab[i].run, tab[i].err);
            end
        end
        bus.in_valid = 1'b0;
        chk_wr("t1", 2, {8'h00, 32'h0010_0013}, {8'h01, 32'h0010_0093});

        // Test 2: garbage before a valid one-word frame.
        do_reset();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
        chk_status("t2_garbage", 16'd0, 1'b1, 1'b0, 1'b0);
        send_frame2(8'h38);
        idle(3);
        chk_wr("t2", 1, {8'h00, 32'hDEAD_BEEF}, 40'h0);
        chk_status("t2", 16'd1, 1'b0, 1'b1, 1'b0);

        // Test 3: N=257 exceeds memory depth.
        do_reset();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        send_byte(8'h11);
        idle(3);
        chk_wr("t3", 0, 40'h0, 40'h0);
        chk_status("t3", 16'd0, 1'b0, 1'b0, 1'b1);

        // Boundary: N=256 is accepted and the loader waits for data.
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        idle(2);
        chk_status("n256", 16'd0, 1'b1, 1'b0, 1'b0);

        // Boundary: N=0 finishes with no writes.
        do_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h00);
`endif
        idle(3);
        chk_wr("n0", 0, 40'h0, 40'h0);
        chk_status("n0", 16'd0, 1'b0, 1'b1, 1'b0);

`ifdef BOOT_CHECKSUM_EN
        // Test 4: bad checksum after a written word.
        do_reset();
        send_frame2(8'h39);
        idle(3);
        chk_wr("t4", 1, {8'h00, 32'hDEAD_BEEF}, 40'h0);
        chk_status("t4", 16'd1, 1'b0, 1'b0, 1'b1);
`endif

        // Test 5: reset after two data bytes, then full replay.
        do_reset();
        for (int k = 0; k < 5; k++) send_byte(f1[k]);
        rst = 1'b1;
        #1;
        chk_status("t5_abort", 16'd0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_wr("t5_abort", 0, 40'h0, 40'h0);
        send_frame1(1'b0);
        idle(3);
        chk_wr("t5", 2, {8'h00, 32'h0010_0013}, {8'h01, 32'h0010_0093});
        chk_status("t5", 16'd2, 1'b0, 1'b1, 1'b0);

        // Test 6: random in_valid gaps.
        do_reset();
        send_frame1(1'b1);
        idle(3);
        chk_wr("t6", 2, {8'h00, 32'h0010_0013}, {8'h01, 32'h0010_0093});
        chk_status("t6", 16'd2, 1'b0, 1'b1, 1'b0);

        cs_last = csum1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
